// File: rtl/wb_apb_bridge_pkg.sv
// Shared types and helpers for the Wishbone-to-APB bridge and its address decoder.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/wb_apb_bridge_if.sv
// Bundled Wishbone-classic slave side and APB master side of the bridge.
interface wb_apb_bridge_if #(
    parameter int unsigned NSLV = 4
);
    logic               wb_cyc;
    logic               wb_stb;
    logic               wb_we;
    logic [31:0]        wb_adr;
    logic [31:0]        wb_dat_w;
    logic [3:0]         wb_sel;
    logic [31:0]        wb_dat_r;
    logic               wb_ack;
    logic               wb_err;

    logic [31:0]        paddr;
    logic [31:0]        pwdata;
    logic [3:0]         pstrb;
    logic               pwrite;
    logic [NSLV-1:0]    psel;
    logic               penable;
    logic [NSLV*32-1:0] prdata;
    logic [NSLV-1:0]    pready;
    logic [NSLV-1:0]    pslverr;

    // Bridge view.
    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel,
        output wb_dat_r, wb_ack, wb_err,
        output paddr, pwdata, pstrb, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    // System view: Wishbone master plus the APB slaves.
    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel,
        input  wb_dat_r, wb_ack, wb_err,
        input  paddr, pwdata, pstrb, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/wb_apb_bridge_decode.sv
// Combinational window decode: byte address -> hit, slave index, one-hot select.
module apb_addr_decode
    import apb_bridge_pkg::*;
#(
    parameter int unsigned NSLV      = 4,
    parameter logic [31:0] BASE      = 32'h4000_0000,
    parameter int unsigned SLV_SHIFT = 12
) (
    input  logic [31:0]             i_adr,
    output logic                    o_hit,
    output logic [clog2(NSLV)-1:0]  o_idx,
    output logic [NSLV-1:0]         o_sel
);
    localparam int unsigned IDXW = clog2(NSLV);
    localparam int unsigned HI   = SLV_SHIFT + IDXW;

    logic w_unused_offset;

    assign o_hit = (i_adr[31:HI] == BASE[31:HI]);
    assign o_idx = i_adr[SLV_SHIFT +: IDXW];
    assign o_sel = o_hit ? (NSLV'(1) << o_idx) : '0;

    assign w_unused_offset = ^i_adr[SLV_SHIFT-1:0];
endmodule

// File: rtl/wb_apb_bridge.sv
// Wishbone-classic slave to APB master bridge, one APB transfer per Wishbone access.
// Define APB_BRIDGE_TIMEOUT_EN to add the ACCESS-phase watchdog.
module wb_apb_bridge
    import apb_bridge_pkg::*;
#(
    parameter int unsigned NSLV      = 4,
    parameter logic [31:0] BASE      = 32'h4000_0000,
    parameter int unsigned SLV_SHIFT = 12,
    parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT
) (
    input logic            pclk,
    input logic            preset,
    wb_apb_bridge_if.slave bus
);
    localparam int unsigned IDXW = clog2(NSLV);

    state_t            r_state, w_next;
    logic [IDXW-1:0]   r_idx;
    logic [NSLV-1:0]   r_sel;
    logic [31:0]       r_paddr, r_pwdata, r_dat_r;
    logic [3:0]        r_pstrb;
    logic              r_pwrite, r_err, r_drop;

    logic              w_hit, w_req, w_rdy, w_slverr, w_timeout;
    logic [IDXW-1:0]   w_idx;
    logic [NSLV-1:0]   w_sel;
    logic [31:0]       w_prdata;

    apb_addr_decode #(
        .NSLV      (NSLV),
        .BASE      (BASE),
        .SLV_SHIFT (SLV_SHIFT)
    ) u_decode (
        .i_adr (bus.wb_adr),
        .o_hit (w_hit),
        .o_idx (w_idx),
        .o_sel (w_sel)
    );

    assign w_req    = bus.wb_cyc & bus.wb_stb;
    assign w_rdy    = bus.pready[r_idx];
    assign w_slverr = bus.pslverr[r_idx];
    assign w_prdata = bus.prdata[32*int'(r_idx) +: 32];

`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam int unsigned WDW = (clog2(TIMEOUT + 1) > 8) ? clog2(TIMEOUT + 1) : 8;
    logic [WDW-1:0] r_wdog;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_wdog <= '0;
        end else if (r_state == SETUP) begin
            r_wdog <= '0;
        end else if (r_state == ACCESS && !w_rdy) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    // Fires on the TIMEOUT-th unready ACCESS cycle.
    assign w_timeout = (r_state == ACCESS) && !w_rdy && (r_wdog == WDW'(TIMEOUT - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req) w_next = w_hit ? SETUP : RESP;
            SETUP:   w_next = ACCESS;
            ACCESS:  if (w_rdy || w_timeout) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_sel    <= '0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
            r_pwrite <= 1'b0;
            r_err    <= 1'b0;
            r_drop   <= 1'b0;
            r_dat_r  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_req) begin
                r_idx    <= w_idx;
                r_sel    <= w_sel;
                r_paddr  <= bus.wb_adr;
                r_pwdata <= bus.wb_dat_w;
                r_pstrb  <= bus.wb_we ? bus.wb_sel : 4'b0000;
                r_pwrite <= bus.wb_we;
                r_err    <= !w_hit;
                r_drop   <= 1'b0;
            end
            // An abandoned cycle still finishes on APB; only the response is withheld.
            if ((r_state == SETUP || r_state == ACCESS) && !bus.wb_cyc) begin
                r_drop <= 1'b1;
            end
            if (r_state == ACCESS) begin
                if (w_rdy) begin
                    r_err <= w_slverr;
                    if (!r_pwrite && !w_slverr) r_dat_r <= w_prdata;
                end else if (w_timeout) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.psel     = (r_state == SETUP || r_state == ACCESS) ? r_sel : '0;
    assign bus.penable  = (r_state == ACCESS);
    assign bus.paddr    = r_paddr;
    assign bus.pwdata   = r_pwdata;
    assign bus.pstrb    = r_pstrb;
    assign bus.pwrite   = r_pwrite;
    assign bus.wb_dat_r = r_dat_r;
    assign bus.wb_ack   = (r_state == RESP) && !r_err && !r_drop;
    assign bus.wb_err   = (r_state == RESP) &&  r_err && !r_drop;
endmodule

// File: tb/tb_wb_apb_bridge.sv
// Directed self-checking bench for wb_apb_bridge with a small configurable APB slave model.
module tb_wb_apb_bridge;
    logic pclk;
    logic preset;

    wb_apb_bridge_if #(.NSLV(4)) bus ();

    wb_apb_bridge #(
        .NSLV      (4),
        .BASE      (32'h4000_0000),
        .SLV_SHIFT (12),
        .TIMEOUT   (8)
    ) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Slave model: wait_cfg < 0 means never ready.
    int          wait_cfg [4];
    logic [31:0] rd_cfg   [4];
    logic        err_cfg  [4];
    int          acc_cnt  [4];

    always @(posedge pclk) begin
        for (int i = 0; i < 4; i++)
            acc_cnt[i] <= (bus.psel[i] && bus.penable) ? acc_cnt[i] + 1 : 0;
    end

    always_comb begin
        bus.pready  = '0;
        bus.pslverr = '0;
        bus.prdata  = '0;
        for (int i = 0; i < 4; i++) begin
            bus.pready[i]        = bus.psel[i] && bus.penable && (wait_cfg[i] >= 0) && (acc_cnt[i] >= wait_cfg[i]);
            bus.pslverr[i]       = err_cfg[i];
            bus.prdata[32*i +: 32] = rd_cfg[i];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one access; latency counts cycles after the sampling edge.
    logic        x_done, x_ack, x_err;
    int          x_lat;
    logic [3:0]  x_psel, x_pstrb, x_psel_or;
    logic        x_pwrite, x_pen_setup;
    logic [31:0] x_paddr, x_pwdata;

    task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, input int limit);
        @(negedge pclk);
        bus.wb_cyc   = 1'b1;
        bus.wb_stb   = 1'b1;
        bus.wb_we    = we;
        bus.wb_adr   = adr;
        bus.wb_dat_w = dat;
        bus.wb_sel   = sel;
        x_done = 1'b0; x_ack = 1'b0; x_err = 1'b0; x_lat = 0; x_psel_or = '0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge pclk);
            x_psel_or = x_psel_or | bus.psel;
            if (k == 1) begin
                x_psel      = bus.psel;
                x_pen_setup = bus.penable;
                x_pstrb     = bus.pstrb;
                x_pwrite    = bus.pwrite;
                x_paddr     = bus.paddr;
                x_pwdata    = bus.pwdata;
            end
            if (bus.wb_ack || bus.wb_err) begin
                x_done = 1'b1;
                x_ack  = bus.wb_ack;
                x_err  = bus.wb_err;
                x_lat  = k;
                bus.wb_cyc = 1'b0;
                bus.wb_stb = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            wait_cfg[i] = 0;
            rd_cfg[i]   = 32'h1111_1111 * (i + 1);
            err_cfg[i]  = 1'b0;
        end
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
        bus.wb_adr = '0; bus.wb_dat_w = '0; bus.wb_sel = '0;
        preset = 1'b1;
        repeat (3) @(negedge pclk);
        chk("rst_psel", 32'(bus.psel), 32'h0);
        chk("rst_penable", 32'(bus.penable), 32'h0);
        chk("rst_ack_err", {30'd0, bus.wb_ack, bus.wb_err}, 32'h0);
        chk("rst_dat_r", bus.wb_dat_r, 32'h0);
        chk("rst_paddr", bus.paddr, 32'h0);
        preset = 1'b0;

        // Zero-wait write to slave 0.
        xfer(32'h4000_0000, 1'b1, 32'h00C8_0064, 4'hF, 20);
        chk("wr_done", 32'(x_done), 32'h1);
        chk("wr_lat", 32'(x_lat), 32'd3);
        chk("wr_ack_err", {30'd0, x_ack, x_err}, 32'h2);
        chk("wr_psel", 32'(x_psel), 32'h1);
        chk("wr_setup_pen", 32'(x_pen_setup), 32'h0);
        chk("wr_pwrite", 32'(x_pwrite), 32'h1);
        chk("wr_pstrb", 32'(x_pstrb), 32'hF);
        chk("wr_paddr", x_paddr, 32'h4000_0000);
        chk("wr_pwdata", x_pwdata, 32'h00C8_0064);
        chk("wr_dat_r_keep", bus.wb_dat_r, 32'h0);

        // One-wait read from slave 2.
        wait_cfg[2] = 1;
        rd_cfg[2]   = 32'hDEAD_BEEF;
        xfer(32'h4000_2004, 1'b0, 32'hFFFF_FFFF, 4'hF, 20);
        chk("rd_done", 32'(x_done), 32'h1);
        chk("rd_lat", 32'(x_lat), 32'd4);
        chk("rd_ack_err", {30'd0, x_ack, x_err}, 32'h2);
        chk("rd_psel", 32'(x_psel), 32'h4);
        chk("rd_pstrb", 32'(x_pstrb), 32'h0);
        chk("rd_pwrite", 32'(x_pwrite), 32'h0);
        chk("rd_dat_r", bus.wb_dat_r, 32'hDEAD_BEEF);

        // Decode miss.
        xfer(32'h5000_0000, 1'b0, 32'h0, 4'hF, 20);
        chk("miss_lat", 32'(x_lat), 32'd1);
        chk("miss_ack_err", {30'd0, x_ack, x_err}, 32'h1);
        chk("miss_psel_or", 32'(x_psel_or), 32'h0);

        // Slave error on slave 1 read.
        err_cfg[1] = 1'b1;
        xfer(32'h4000_1008, 1'b0, 32'h0, 4'hF, 20);
        chk("slverr_lat", 32'(x_lat), 32'd3);
        chk("slverr_ack_err", {30'd0, x_ack, x_err}, 32'h1);
        chk("slverr_psel", 32'(x_psel), 32'h2);
        chk("slverr_dat_r", bus.wb_dat_r, 32'hDEAD_BEEF);
        err_cfg[1] = 1'b0;

        // Partial write to slave 3 with a top-of-window offset.
        xfer(32'h4000_3FFC, 1'b1, 32'hA5A5_0001, 4'h3, 20);
        chk("wr3_lat", 32'(x_lat), 32'd3);
        chk("wr3_psel", 32'(x_psel), 32'h8);
        chk("wr3_pstrb", 32'(x_pstrb), 32'h3);
        chk("wr3_dat_r", bus.wb_dat_r, 32'hDEAD_BEEF);

        // Hung slave 3.
        wait_cfg[3] = -1;
`ifdef APB_BRIDGE_TIMEOUT_EN
        xfer(32'h4000_3000, 1'b0, 32'h0, 4'hF, 50);
        chk("to_done", 32'(x_done), 32'h1);
        chk("to_lat", 32'(x_lat), 32'd10);
        chk("to_ack_err", {30'd0, x_ack, x_err}, 32'h1);
        chk("to_dat_r", bus.wb_dat_r, 32'hDEAD_BEEF);
        xfer(32'h4000_3000, 1'b0, 32'h0, 4'hF, 4);
        chk("hang_done", 32'(x_done), 32'h0);
`else
        xfer(32'h4000_3000, 1'b0, 32'h0, 4'hF, 1000);
        chk("hang_done", 32'(x_done), 32'h0);
        chk("hang_penable", 32'(bus.penable), 32'h1);
`endif

        // Reset while in ACCESS, between clock edges.
        #2;
        preset = 1'b1;
        #1;
        chk("arst_psel", 32'(bus.psel), 32'h0);
        chk("arst_penable", 32'(bus.penable), 32'h0);
        chk("arst_ack", 32'(bus.wb_ack), 32'h0);
        chk("arst_dat_r", bus.wb_dat_r, 32'h0);
        bus.wb_cyc = 1'b0;
        bus.wb_stb = 1'b0;
        wait_cfg[3] = 0;
        repeat (2) @(negedge pclk);
        preset = 1'b0;

        rd_cfg[0] = 32'h1234_5678;
        xfer(32'h4000_0010, 1'b0, 32'h0, 4'hF, 20);
        chk("post_lat", 32'(x_lat), 32'd3);
        chk("post_ack_err", {30'd0, x_ack, x_err}, 32'h2);
        chk("post_psel", 32'(x_psel), 32'h1);
        chk("post_dat_r", bus.wb_dat_r, 32'h1234_5678);

        repeat (2) @(negedge pclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
